// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole engine.
//   state_e           : game state encoding (also driven onto the state port)
//   lifetime_f/...    : per-difficulty mole lifetime, concurrency and points
//   LFSR_POLY/SEED    : Galois LFSR feedback mask and power-on seed
package whack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // mole lifetime in steps: 8, 4, 2, 1
  function automatic logic [3:0] lifetime_f(input logic [1:0] d);
    return 4'd8 >> d;
  endfunction

  function automatic logic [2:0] max_active_f(input logic [1:0] d);
    return {1'b0, d} + 3'd1;
  endfunction

  function automatic logic [2:0] points_f(input logic [1:0] d);
    return {1'b0, d} + 3'd1;
  endfunction

endpackage

// File: rtl/whack_game_core_lfsr16.sv
// Free-running 16-bit Galois LFSR used to pick spawn holes.
//   clk, rst : clock, async active-high reset (reloads LFSR_SEED)
//   lfsr     : current register value
module lfsr16
  import whack_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/whack_game_core.sv
// Whack-a-mole game engine: timed round, pseudo-random mole spawns,
// tap scoring, pause/resume.
//   clk, rst        : clock, async active-high reset
//   start, pause    : one-cycle control pulses
//   difficulty      : latched on an accepted start
//   tap             : per-hole tap pulses
//   holes           : mole visible per hole
//   score, misses   : score (saturating/floored), wrong-tap count (sat 255)
//   time_left       : seconds remaining in the round
//   state           : 0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER
//   game_over       : one-cycle pulse on entry to OVER
module whack_game_core
  import whack_pkg::*;
#(
  parameter int NUM_HOLES    = 8,
  parameter int SCORE_W      = 12,
  parameter int TICK_DIV     = 100_000_000,
  parameter int STEP_DIV     = 12_500_000,
  parameter int GAME_SECONDS = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  input  logic [1:0]           difficulty,
  input  logic [NUM_HOLES-1:0] tap,
  output logic [NUM_HOLES-1:0] holes,
  output logic [SCORE_W-1:0]   score,
  output logic [7:0]           misses,
  output logic [5:0]           time_left,
  output logic [1:0]           state,
  output logic                 game_over
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int NET_W  = SCORE_W + 8;  // headroom for +64 / -16 in one cycle

  state_e               state_q, state_d;
  logic [1:0]           d_q, d_d;
  logic [NUM_HOLES-1:0] holes_q, holes_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [7:0]           misses_q, misses_d;
  logic [5:0]           time_left_q, time_left_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic                 game_over_q, game_over_d;

  logic [15:0]          lfsr;
  logic                 lfsr_unused;
  logic                 play, start_acc, step_wrap;
  logic [NUM_HOLES-1:0] hit, wrong, escape, spawn, cand_oh;
  logic [3:0]           cand, life;
  logic [4:0]           nhit, nwrong, nact;
  logic [NET_W-1:0]     net;
  logic [8:0]           msum;

  lfsr16 u_lfsr (.clk(clk), .rst(rst), .lfsr(lfsr));
  assign lfsr_unused = ^lfsr[15:4];

  assign play      = (state_q == ST_PLAY);
  assign start_acc = start && (state_q == ST_IDLE || state_q == ST_OVER);
  assign step_wrap = play && (step_q == STEP_W'(STEP_DIV - 1));
  assign hit       = play ? (tap & holes_q) : '0;
  assign wrong     = play ? (tap & ~holes_q) : '0;
  assign life      = lifetime_f(d_q);
  assign cand      = 4'(int'(lfsr[3:0]) % NUM_HOLES);

  // Spawn decision looks only at start-of-cycle occupancy.
  always_comb begin
    nhit    = '0;
    nwrong  = '0;
    nact    = '0;
    cand_oh = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      nhit       = nhit + 5'(hit[i]);
      nwrong     = nwrong + 5'(wrong[i]);
      nact       = nact + 5'(holes_q[i]);
      cand_oh[i] = (cand == 4'(i));
    end
    spawn = '0;
    if (step_wrap && !(|(cand_oh & holes_q)) && (nact < {2'b00, max_active_f(d_q)}))
      spawn = cand_oh;
  end

  // Per-hole age; a hit on the escape cycle takes priority over escape.
  for (genvar g = 0; g < NUM_HOLES; g++) begin : g_hole
    logic [2:0] age_q, age_d;
    logic       aging;
    assign aging     = step_wrap && holes_q[g] && !hit[g];
    assign escape[g] = aging && (({1'b0, age_q} + 4'd1) == life);
    always_comb begin
      age_d = age_q;
      if (start_acc)     age_d = '0;
      else if (spawn[g]) age_d = '0;
      else if (aging)    age_d = age_q + 3'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) age_q <= '0;
      else     age_q <= age_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    holes_d     = holes_q;
    score_d     = score_q;
    misses_d    = misses_q;
    time_left_d = time_left_q;
    tick_d      = tick_q;
    step_d      = step_q;
    game_over_d = 1'b0;
    net         = '0;
    msum        = '0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d     = ST_PLAY;
          d_d         = difficulty;
          holes_d     = '0;
          score_d     = '0;
          misses_d    = '0;
          tick_d      = '0;
          step_d      = '0;
          time_left_d = 6'(GAME_SECONDS);
        end
      end
      ST_PAUSE: if (pause) state_d = ST_PLAY;
      default: begin
        holes_d = (holes_q & ~hit & ~escape) | spawn;
        // net score computed modulo 2^NET_W; MSB set means it went negative
        net = NET_W'(score_q) + NET_W'(points_f(d_q)) * NET_W'(nhit) - NET_W'(nwrong);
        if (net[NET_W-1])                        score_d = '0;
        else if (net > NET_W'({SCORE_W{1'b1}})) score_d = '1;
        else                                     score_d = net[SCORE_W-1:0];
        msum     = {1'b0, misses_q} + {4'b0000, nwrong};
        misses_d = msum[8] ? 8'hFF : msum[7:0];
        step_d   = step_wrap ? '0 : step_q + 1'b1;
        if (tick_q == TICK_W'(TICK_DIV - 1)) begin
          tick_d      = '0;
          time_left_d = time_left_q - 6'd1;
          if (time_left_q == 6'd1) begin
            state_d     = ST_OVER;
            holes_d     = '0;
            game_over_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
        if (pause && state_d == ST_PLAY) state_d = ST_PAUSE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      d_q         <= '0;
      holes_q     <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      time_left_q <= '0;
      tick_q      <= '0;
      step_q      <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      holes_q     <= holes_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      time_left_q <= time_left_d;
      tick_q      <= tick_d;
      step_q      <= step_d;
      game_over_q <= game_over_d;
    end
  end

  assign holes     = holes_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign time_left = time_left_q;
  assign state     = state_q;
  assign game_over = game_over_q;

endmodule

// File: doc/whack_game_core.md
# whack_game_core

Parametrised whack-a-mole game engine; successor to the fixed 8-hole game logic. Runs a timed round, spawns moles pseudo-randomly into `NUM_HOLES` holes with difficulty-dependent lifetime and concurrency, scores taps, and supports pause and restart. It sits between the tap decoder (mouse/buttons) and the VGA/score display, and it replaces the separate 30-second time counter.

## Interface
- `NUM_HOLES`, 8: number of holes, range 2..16.
- `SCORE_W`, 12: score width.
- `TICK_DIV`, 100_000_000: clk cycles per game second.
- `STEP_DIV`, 12_500_000: clk cycles per mole step.
- `GAME_SECONDS`, 30: round length in seconds, range 1..63.
- `clk  in  1`: system clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `start  in  1`: one-cycle pulse; begins a new round from IDLE or OVER.
- `pause  in  1`: one-cycle pulse; toggles between PLAY and PAUSE.
- `difficulty  in  2`: sampled only on an accepted `start`.
- `tap  in  NUM_HOLES`: one-cycle per-hole tap pulses.
- `holes  out  NUM_HOLES`: mole visible per hole.
- `score  out  SCORE_W`: current score.
- `misses  out  8`: wrong-tap count, saturating at 255.
- `time_left  out  6`: seconds remaining.
- `state  out  2`: 0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER.
- `game_over  out  1`: one-cycle pulse on entry to OVER.

## Operation
- Reset: state IDLE. `holes`, `score`, `misses`, `time_left` and `game_over` are 0. All counters are 0. LFSR is loaded with 16'hACE1.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It advances every cycle in every state and is never reseeded by `start`.
- Difficulty is latched as `d` on start. It sets three values:
  - lifetime = 8 >> d steps (8, 4, 2, 1).
  - max_active = d+1.
  - points = d+1.
- IDLE/OVER + `start`: go to PLAY. Clear score, misses, holes, all mole ages, tick counter and step counter. Set `time_left` = GAME_SECONDS.
- PLAY, tick counter: counts 0..TICK_DIV-1. On wrap, `time_left` decrements. When it becomes 0, go to OVER, clear `holes` and pulse `game_over`.
- PLAY, step counter: counts 0..STEP_DIV-1. On wrap, every visible mole's 3-bit age increments. A mole whose new age equals lifetime is cleared (escape; no penalty).
- PLAY, spawn (same step-wrap cycle): candidate = lfsr[3:0] mod NUM_HOLES. Set the candidate hole with age 0 only if all of these hold at the start of the cycle:
  - the hole is empty;
  - popcount(holes) < max_active;
  - the hole was not hit this cycle.
  - Otherwise no spawn this step.
- PLAY, taps: each bit is evaluated independently.
  - Hit (`tap[i] & holes[i]`): clear the hole; score += points, saturating at all-ones.
  - Wrong tap (`tap[i] & ~holes[i]`): misses += 1 per bit, saturating; score -= 1 per bit, floored at 0.
  - Several bits in one cycle: all hits and all wrong taps are summed, then one saturate/floor is applied to the net result.
  - Hit and escape on the same hole in the same cycle: the hit wins.
- PAUSE: all counters, ages and holes are frozen. Taps and `start` are ignored. `pause` returns to PLAY with counters resuming from their frozen values.
- `pause` in IDLE/OVER is ignored. `start` in PLAY/PAUSE is ignored.
- Round ending on the same cycle as a tap: the tap is scored, then the holes are cleared.
- `rst` mid-round: immediate return to reset values.

## Timing
- All outputs are registered. Tap in cycle n is reflected in `holes`/`score`/`misses` at cycle n+1.
- `start` at cycle n gives state=PLAY and `time_left`=GAME_SECONDS at n+1. The first decrement is visible at n+1+TICK_DIV. OVER is reached at n+1+GAME_SECONDS·TICK_DIV.
- The first step wrap after start is at n+STEP_DIV. A spawned mole is visible the next cycle.
- `game_over` is high for exactly the one cycle where `state` first reads 3.
- `pause` latency is 1 cycle. The remaining tick/step cycle counts are preserved across pause.

## Structure
- Package `whack_pkg` holds:
  - the state enum;
  - the lifetime/max_active/points lookup functions of `d`;
  - the LFSR polynomial and seed constants.
- Sub-module `lfsr16`: free-running generator with async reset. All other logic is in one module, with the per-hole age registers in a generate loop.

## Test plan
Bench parameters: NUM_HOLES=4, TICK_DIV=10, STEP_DIV=4, GAME_SECONDS=3, SCORE_W=8.
- `start` at cycle 0 with no taps:
  - `time_left` reads 3, then 2 at cycle 11, 1 at cycle 21, 0 at cycle 31;
  - state=3, `game_over` high for 1 cycle at 31, holes=0.
- d=0: after the first spawn, tap that hole -> score=1 and hole cleared next cycle. A tap on an empty hole -> misses=1 and score=0 (floor).
- d=3:
  - a spawned mole survives exactly one step and clears at the next wrap;
  - popcount(holes) never exceeds 4, and never exceeds 1 with d=0;
  - a hit scores 4.
- Pause for 50 cycles mid-round: `time_left`, holes and ages are unchanged. After resume, the next decrement occurs at the preserved remaining count.
- Tap on a hole in the cycle its age reaches lifetime -> counted as a hit (+points). Taps on two occupied holes in one cycle -> score += 2·points.
- Assert `rst` mid-round -> all outputs 0 and state IDLE next cycle. `start` in PLAY ignored. Score saturates at 255 under repeated hits.
